// File: rtl/feedback_pkg.sv
// Shared types and default constants for the feedback packet builder.
package feedback_pkg;

  typedef enum logic [2:0] {
    FieldSrc,
    FieldBatt,
    FieldQval,
    FieldClus,
    FieldDest,
    FieldCsum
  } field_e;

  typedef enum logic [2:0] {
    StIdle,
    StEmit,
    StIssue,
    StWait,
    StDone
  } state_e;

  localparam int unsigned DefBattBase = 'h148;
  localparam int unsigned DefQvalBase = 'h1C8;
  localparam int unsigned DefDestBase = 'h48;
  localparam int unsigned DefStride   = 2;

  function automatic logic is_mem_field(field_e f);
    return (f == FieldBatt) || (f == FieldQval) || (f == FieldDest);
  endfunction

endpackage

// File: rtl/fb_mem_reader.sv
// Single-outstanding node memory read: strobes one request, counts RD_LAT cycles,
// then captures read data and flags it for one cycle.
module fb_mem_reader #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic                  rdata_valid,
  output logic [WORD_WIDTH-1:0] rdata
);

  // RD_LAT is limited to 1..4, so two counter bits suffice.
  localparam int unsigned CntW = 2;

  logic                  wait_q, wait_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    wait_d      = wait_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rdata_valid = 1'b0;
    if (req) begin
      wait_d = 1'b1;
      cnt_d  = '0;
    end else if (wait_q) begin
      if (cnt_q == CntW'(RD_LAT - 1)) begin
        rdata_valid = 1'b1;
        rdata_d     = data_in;
        wait_d      = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wait_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_rd  = req;
  assign address = req ? req_addr : '0;
  assign rdata   = rdata_q;

endmodule

// File: rtl/feedback_builder.sv
// Assembles one Q-routing feedback packet per start pulse and streams it over valid/ready.
// Define FEEDBACK_CHECKSUM_EN to append an XOR checksum word after the destination word.
module feedback_builder
  import feedback_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BATT_BASE  = DefBattBase,
  parameter int unsigned QVAL_BASE  = DefQvalBase,
  parameter int unsigned DEST_BASE  = DefDestBase,
  parameter int unsigned STRIDE     = DefStride,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] action,
  input  logic [WORD_WIDTH-1:0] besthop,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic [WORD_WIDTH-1:0] my_cluster_id,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

`ifdef FEEDBACK_CHECKSUM_EN
  localparam field_e LastField = FieldCsum;
`else
  localparam field_e LastField = FieldDest;
`endif

  state_e                state_q, state_d;
  field_e                field_q, field_d, field_nxt;
  logic [WORD_WIDTH-1:0] node_q, node_d;
  logic [WORD_WIDTH-1:0] clus_q, clus_d;
  logic [WORD_WIDTH-1:0] act_q, act_d;
  logic [WORD_WIDTH-1:0] hop_q, hop_d;
`ifdef FEEDBACK_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] csum_q, csum_d;
`endif

  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rdata_valid;
  logic [WORD_WIDTH-1:0] rdata;
  logic [WORD_WIDTH-1:0] word;
  logic                  emit;

  assign field_nxt = field_e'(field_q + 3'd1);
  assign emit      = (state_q == StEmit);
  assign rd_req    = (state_q == StIssue);

  // Table lookups wrap modulo 2^ADDR_WIDTH by construction.
  always_comb begin
    rd_addr = ADDR_WIDTH'(DEST_BASE) + ADDR_WIDTH'(act_q) * ADDR_WIDTH'(STRIDE);
    case (field_q)
      FieldBatt: rd_addr = ADDR_WIDTH'(BATT_BASE) + ADDR_WIDTH'(node_q) * ADDR_WIDTH'(STRIDE);
      FieldQval: rd_addr = ADDR_WIDTH'(QVAL_BASE) + ADDR_WIDTH'(hop_q) * ADDR_WIDTH'(STRIDE);
      default:   ;
    endcase
  end

  always_comb begin
    case (field_q)
      FieldSrc:  word = node_q;
      FieldClus: word = clus_q;
`ifdef FEEDBACK_CHECKSUM_EN
      FieldCsum: word = csum_q;
`endif
      default:   word = rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    node_d  = node_q;
    clus_d  = clus_q;
    act_d   = act_q;
    hop_d   = hop_q;
`ifdef FEEDBACK_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          node_d  = my_node_id;
          clus_d  = my_cluster_id;
          act_d   = action;
          hop_d   = besthop;
          field_d = FieldSrc;
          state_d = StEmit;
`ifdef FEEDBACK_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StEmit: begin
        if (out_ready) begin
`ifdef FEEDBACK_CHECKSUM_EN
          csum_d = csum_q ^ word;
`endif
          if (field_q == LastField) begin
            state_d = StDone;
          end else begin
            field_d = field_nxt;
            state_d = is_mem_field(field_nxt) ? StIssue : StEmit;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait:  if (rdata_valid) state_d = StEmit;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      field_q <= FieldSrc;
      node_q  <= '0;
      clus_q  <= '0;
      act_q   <= '0;
      hop_q   <= '0;
`ifdef FEEDBACK_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      node_q  <= node_d;
      clus_q  <= clus_d;
      act_q   <= act_d;
      hop_q   <= hop_d;
`ifdef FEEDBACK_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  fb_mem_reader #(
    .WORD_WIDTH(WORD_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RD_LAT    (RD_LAT)
  ) u_reader (
    .clock      (clock),
    .nreset     (nreset),
    .req        (rd_req),
    .req_addr   (rd_addr),
    .mem_rd     (mem_rd),
    .address    (address),
    .data_in    (data_in),
    .rdata_valid(rdata_valid),
    .rdata      (rdata)
  );

  assign out_valid = emit;
  assign out_data  = emit ? word : '0;
  assign out_last  = emit && (field_q == LastField);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_feedback_builder.sv
// Directed bench for feedback_builder: one instance at RD_LAT=1 and one at RD_LAT=4
// share stimulus and a latency-accurate node memory model.
module tb_feedback_builder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, start4 = 1'b0;
  logic [15:0] action = '0, besthop = '0, nid = '0, cid = '0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;

  logic        mem_rd1, mem_rd4, ov1, ov4, ol1, ol4, busy1, busy4, done1, done4;
  logic [15:0] addr1, addr4, din1, din4, od1, od4;

  logic        mem_rd, out_valid, out_last, busy, done;
  logic [15:0] address, out_data;

  assign mem_rd    = sel ? mem_rd4 : mem_rd1;
  assign address   = sel ? addr4   : addr1;
  assign out_valid = sel ? ov4     : ov1;
  assign out_last  = sel ? ol4     : ol1;
  assign out_data  = sel ? od4     : od1;
  assign busy      = sel ? busy4   : busy1;
  assign done      = sel ? done4   : done1;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    case (a)
      16'h014E: return 16'h0010;
      16'h01D2: return 16'h0020;
      16'h004C: return 16'h0040;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  // Read pipeline: data appears exactly N cycles after the strobe, garbage otherwise.
  logic [3:0]       pv = '0;
  logic [3:0][15:0] pa = '0;
  always @(posedge clk) begin
    pv[0] <= mem_rd;
    pa[0] <= address;
    for (int i = 1; i < 4; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign din1 = pv[0] ? mem_f(pa[0]) : 16'hDEAD;
  assign din4 = pv[3] ? mem_f(pa[3]) : 16'hBEEF;

  feedback_builder #(.RD_LAT(1)) dut1 (
    .clock(clk), .nreset(rst_n), .start(start1), .action(action), .besthop(besthop),
    .my_node_id(nid), .my_cluster_id(cid), .mem_rd(mem_rd1), .address(addr1),
    .data_in(din1), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_last(ol1), .busy(busy1), .done(done1)
  );

  feedback_builder #(.RD_LAT(4)) dut4 (
    .clock(clk), .nreset(rst_n), .start(start4), .action(action), .besthop(besthop),
    .my_node_id(nid), .my_cluster_id(cid), .mem_rd(mem_rd4), .address(addr4),
    .data_in(din4), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .out_last(ol4), .busy(busy4), .done(done4)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    start1 = v && !sel;
    start4 = v && sel;
  endtask

  task automatic run_pkt(input string name, input logic s, input logic [15:0] n, h, a, c,
                         input logic [15:0] ea0, ea1, ea2, input int ei0,
                         input int stall_word, input int stall_n, input int restart_cyc,
                         input int exp_done_base);
    logic [15:0] exp_w [6];
    logic [15:0] ea [3];
    int cyc, widx, ridx, stalled, nw, exp_done;
    bit got_done;
    ea = '{ea0, ea1, ea2};
    exp_w[0] = n;
    exp_w[1] = mem_f(ea0);
    exp_w[2] = mem_f(ea1);
    exp_w[3] = c;
    exp_w[4] = mem_f(ea2);
    exp_w[5] = exp_w[0] ^ exp_w[1] ^ exp_w[2] ^ exp_w[3] ^ exp_w[4];
`ifdef FEEDBACK_CHECKSUM_EN
    nw = 6;
    exp_done = exp_done_base + 1;
`else
    nw = 5;
    exp_done = exp_done_base;
`endif
    cyc = 0; widx = 0; ridx = 0; stalled = 0; got_done = 0;
    sel = s;
    @(posedge clk); #1;
    nid = n; besthop = h; action = a; cid = c; out_ready = 1'b1;
    drive_start(1'b1);
    while (!got_done && cyc < 80) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (mem_rd) begin
        if (ridx < 3) check_eq({name, "_addr"}, 32'(address), 32'(ea[ridx]));
        else check_eq({name, "_extra_read"}, 32'(mem_rd), 32'd0);
        if (ridx == 0) check_eq({name, "_issue0_cyc"}, cyc, ei0);
        ridx++;
      end
      if (out_valid) begin
        if (widx == stall_word && stalled < stall_n) begin
          out_ready = 1'b0;
          stalled++;
          check_eq({name, "_stall_data"}, 32'(out_data), 32'(exp_w[widx]));
          check_eq({name, "_stall_last"}, 32'(out_last), 32'd0);
          check_eq({name, "_stall_nord"}, 32'(mem_rd), 32'd0);
        end else if (widx < nw) begin
          check_eq({name, "_word"}, 32'(out_data), 32'(exp_w[widx]));
          check_eq({name, "_last"}, 32'(out_last), 32'(widx == nw - 1));
          widx++;
        end else begin
          check_eq({name, "_extra_word"}, 32'(out_valid), 32'd0);
        end
      end
      if (done) begin
        got_done = 1;
        check_eq({name, "_done_cyc"}, cyc, exp_done);
        check_eq({name, "_word_count"}, widx, nw);
        check_eq({name, "_read_count"}, ridx, 3);
      end
      @(posedge clk); #1;
      cyc++;
      drive_start(cyc == restart_cyc);
      if (cyc == 1) begin
        nid = ~n; besthop = ~h; action = ~a; cid = ~c;
      end
    end
    if (!got_done) check_eq({name, "_timeout"}, 32'(got_done), 32'd1);
    drive_start(1'b0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq({name, "_post_done"}, 32'(done), 32'd0);
      check_eq({name, "_post_busy"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #12;
    check_eq("rst_busy",   32'({busy1, busy4}), 32'd0);
    check_eq("rst_valid",  32'({ov1, ov4, ol1, ol4}), 32'd0);
    check_eq("rst_done",   32'({done1, done4}), 32'd0);
    check_eq("rst_mem_rd", 32'({mem_rd1, mem_rd4}), 32'd0);
    check_eq("rst_data",   {od1, od4}, 32'd0);
    check_eq("rst_addr",   {addr1, addr4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic packet.
    run_pkt("basic", 1'b0, 16'd3, 16'd5, 16'd2, 16'd7,
            16'h014E, 16'h01D2, 16'h004C, 2, -1, 0, -1, 12);
    // RD_LAT=4 sweep.
    run_pkt("lat4", 1'b1, 16'd1, 16'd0, 16'd7, 16'd9,
            16'h014A, 16'h01C8, 16'h0056, 2, -1, 0, -1, 21);
    // Five stalled cycles on word 2.
    run_pkt("bp", 1'b0, 16'd4, 16'd2, 16'd0, 16'h0055,
            16'h0150, 16'h01CC, 16'h0048, 2, 2, 5, -1, 17);
    // Address wrap, plus a start while busy that must be dropped.
    run_pkt("wrap", 1'b0, 16'h0010, 16'hFFFF, 16'hFFFF, 16'hABCD,
            16'h0168, 16'h01C6, 16'h0046, 2, -1, 0, 3, 12);

    // Reset during the field-2 wait (cycle 6 at RD_LAT=1).
    sel = 1'b0;
    @(posedge clk); #1;
    nid = 16'd3; besthop = 16'd5; action = 16'd2; cid = 16'd7;
    drive_start(1'b1);
    repeat (6) begin
      @(posedge clk); #1;
      drive_start(1'b0);
    end
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",  32'(busy), 32'd0);
    check_eq("mid_rst_valid", 32'({out_valid, out_last}), 32'd0);
    check_eq("mid_rst_rd",    32'(mem_rd), 32'd0);
    check_eq("mid_rst_addr",  32'(address), 32'd0);
    check_eq("mid_rst_data",  32'(out_data), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("mid_rst_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("no_resume", 32'({busy, out_valid, done}), 32'd0);
    end
    run_pkt("after_rst", 1'b0, 16'd3, 16'd5, 16'd2, 16'd7,
            16'h014E, 16'h01D2, 16'h004C, 2, -1, 0, -1, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/feedback_builder.md
# feedback_builder

Parametrised successor to the single-width feedback packet assembler in the Q-routing node datapath. On a `start` pulse, it assembles one feedback packet of five words: source ID, battery status, Q-value, cluster ID and destination ID. The battery, Q-value and destination words are fetched from node memory with a configurable read latency. Words stream out over a valid/ready handshake with full backpressure, and a `done` pulse follows the last accepted word. The block sits between the action selector and the packet transmit queue.

## Interface
Parameters:
- `WORD_WIDTH`, 16, width of every packet word and of every ID/index input.
- `ADDR_WIDTH`, 16, node memory address width.
- `BATT_BASE`, 'h148, battery table base address, indexed by `my_node_id`.
- `QVAL_BASE`, 'h1C8, Q-value table base address, indexed by `besthop`.
- `DEST_BASE`, 'h48, destination table base address, indexed by `action`.
- `STRIDE`, 2, address step per table entry.
- `RD_LAT`, 1, memory read latency in cycles; legal range 1..4.

Ports:
- `clock`  in  1  single clock, rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one packet; sampled only in IDLE.
- `action`  in  WORD_WIDTH  chosen action index.
- `besthop`  in  WORD_WIDTH  best next-hop index.
- `my_node_id`  in  WORD_WIDTH  source ID.
- `my_cluster_id`  in  WORD_WIDTH  cluster ID.
- `mem_rd`  out  1  one-cycle read strobe.
- `address`  out  ADDR_WIDTH  read address; valid while `mem_rd`=1.
- `data_in`  in  WORD_WIDTH  read data; valid RD_LAT cycles after `mem_rd`.
- `out_valid`  out  1  `out_data` holds a packet word.
- `out_ready`  in  1  sink accepts the word.
- `out_data`  out  WORD_WIDTH  packet word.
- `out_last`  out  1  high with the final word.
- `busy`  out  1  packet in progress.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States:
  - IDLE: `start`=1 latches all four inputs and moves to EMIT with field=0.
  - EMIT: holds one word with `out_valid`=1. On accept, it advances field. The next field goes to ISSUE if it is a memory field, or stays in EMIT if it is a constant field. After the final field it goes to DONE.
  - ISSUE: one cycle with `mem_rd`=1 and `address` driven; then WAIT.
  - WAIT: counts RD_LAT cycles, captures `data_in` in the final one, then goes to EMIT.
  - DONE: one cycle with `done`=1, then IDLE.
- Field order and source:
  - 0: latched `my_node_id`.
  - 1: memory read at BATT_BASE + `my_node_id`*STRIDE.
  - 2: memory read at QVAL_BASE + `besthop`*STRIDE.
  - 3: latched `my_cluster_id`.
  - 4: memory read at DEST_BASE + `action`*STRIDE.
- Address arithmetic is done in ADDR_WIDTH bits. Overflow wraps modulo 2^ADDR_WIDTH with no error.
- Inputs are latched at start, so changes mid-packet have no effect.
- `start` is ignored while `busy`=1; no request is queued.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable and no read is issued.
- `out_ready` while `out_valid`=0 is ignored.
- `busy`=1 in every state except IDLE.

## Timing
- All outputs reset to 0; the FSM resets to IDLE; the field counter and latches reset to 0.
- `nreset` low mid-packet aborts immediately. No `done` pulse follows, and the packet is not resumed.
- Reference schedule, with `start` high in cycle 0, `out_ready`=1 and RD_LAT=1:
  - Word0 is valid in cycle 1.
  - ISSUE in cycles 2, 5 and 9.
  - Words 1–4 are valid in cycles 4, 7, 8 and 11.
  - `done` in cycle 12.
- Each memory field costs RD_LAT+2 cycles; each constant field costs 1 cycle.
- A new `start` is accepted in the cycle after `done` (back-to-back operation).

## Configuration
- `FEEDBACK_CHECKSUM_EN` defined:
  - A sixth word, the XOR of words 0–4, is emitted in EMIT after word4 with no extra memory access.
  - `out_last` moves to the checksum word, and `done` is delayed by 1 cycle.
- Undefined: the packet is five words, with `out_last` on word4.

## Structure
- `feedback_pkg` holds:
  - the field index enum (SRC, BATT, QVAL, CLUS, DEST, CSUM);
  - the FSM state encoding;
  - the default base constants.
- Sub-module `fb_mem_reader` handles ISSUE/WAIT, RD_LAT counting and data capture. Interface: `req`, `req_addr`, `rdata_valid`, `rdata`.

## Test plan
- Basic packet: RD_LAT=1, `out_ready`=1, `my_node_id`=3, `besthop`=5, `action`=2, `my_cluster_id`=7 -> reads at 'h14E, 'h1D2, 'h4C. Words are 3, mem['h14E], mem['h1D2], 7, mem['h4C]; `done` pulses in cycle 12 only.
- Backpressure: `out_ready`=0 for 5 cycles on word2 -> `out_data` is stable throughout, `mem_rd` stays 0, and word order is unchanged.
- Latency sweep: RD_LAT=4 -> each read is captured exactly 4 cycles after `mem_rd`, and `done` falls in cycle 21.
- Wrap and ignore: `besthop`='hFFFF -> address ('h1C8+'h1FFFE) mod 2^16 = 'h1C6. A second `start` while busy produces no second packet.
- Reset mid-packet: `nreset` low during the WAIT for field 2 -> all outputs are 0 and there is no `done`. A fresh `start` after release yields a complete correct packet.
- `FEEDBACK_CHECKSUM_EN`: words 3, 'h10, 'h20, 7, 'h40 -> word5='h74 with `out_last`=1, and `done` in cycle 13.
